subtrator_serial: RTL

//   Bit-serial WIDTH-bit subtractor: computes d = a - b - bin, one bit per clock, LSB first.

---
 rtl/subtrator_serial.sv | 118 +++++++++++
 1 files changed

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell reused over WIDTH cycles, with a start/ready/done handshake.
module subtrator_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned IW  = $clog2(WIDTH) + 1;
  localparam int unsigned AW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_d_nxt;
  logic [IW-1:0]    r_i, w_i_nxt;
  logic             r_borrow, w_borrow_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_done, w_done_nxt;
  logic             r_bout, w_bout_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [AW-1:0]    w_idx;
  logic             w_ai, w_bi;

  assign w_idx = r_i[AW-1:0];
  assign w_ai  = r_a[w_idx];
  assign w_bi  = r_b[w_idx];

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_i      <= '0;
      r_borrow <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_d      <= w_d_nxt;
      r_i      <= w_i_nxt;
      r_borrow <= w_borrow_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_bout   <= w_bout_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_d_nxt      = r_d;
    w_i_nxt      = r_i;
    w_borrow_nxt = r_borrow;
    w_done_nxt   = 1'b0;
    w_bout_nxt   = r_bout;
    w_ovf_nxt    = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt      = a;
          w_b_nxt      = b;
          w_borrow_nxt = bin;
          w_i_nxt      = '0;
          w_state_nxt  = S_CALC;
        end
      end
      S_CALC: begin
        w_d_nxt[w_idx] = w_ai ^ w_bi ^ r_borrow;
        w_borrow_nxt   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
        w_i_nxt        = r_i + IW'(1);
        if (r_i == IW'(WIDTH - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_bout_nxt  = r_borrow;
        w_ovf_nxt   = (r_a[MSB] != r_b[MSB]) & (r_d[MSB] != r_a[MSB]);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign d     = r_d;
  assign bout  = r_bout;
  assign ovf   = r_ovf;

endmodule
